// File: rtl/wb_stage_rf_pkg.sv
// Shared definitions for the write-back stage: widths, MEM->WB field layout
// and the result-select helper. The MEM stage packs its register with the
// same constants.
package wb_stage_rf_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;
  localparam int unsigned PIPE_W     = 2 * DATA_W + 1 + REG_ADDR_W + 1;

  // MEM->WB field bit positions
  localparam int unsigned ALU_RES_HI  = 36;
  localparam int unsigned ALU_RES_LO  = 21;
  localparam int unsigned MEM_DATA_HI = 20;
  localparam int unsigned MEM_DATA_LO = 5;
  localparam int unsigned WB_EN_BIT   = 4;
  localparam int unsigned WB_DEST_HI  = 3;
  localparam int unsigned WB_DEST_LO  = 1;
  localparam int unsigned WB_MUX_BIT  = 0;

  // Packed view of the MEM->WB register, MSB first
  typedef struct packed {
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     mem_read_data;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic                  wb_mux;
  } mem_wb_t;

  // Result select: 0 -> ALU result, 1 -> memory read data
  function automatic logic [DATA_W-1:0] wb_select(input mem_wb_t p);
    return p.wb_mux ? p.mem_read_data : p.alu_result;
  endfunction

endpackage

// File: rtl/wb_stage_rf_if.sv
// Write-back stage bus: MEM->WB register in, decode read ports, hazard and
// forwarding outputs.
//   master: MEM stage / decode side (drives register and read addresses)
//   slave : wb_stage_rf
interface wb_stage_rf_if;
  import wb_stage_rf_pkg::*;

  logic [PIPE_W-1:0]     pipeline_reg_in;
  logic [REG_ADDR_W-1:0] rd_addr_a;
  logic [REG_ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0]     rd_data_a;
  logic [DATA_W-1:0]     rd_data_b;
  logic [REG_ADDR_W-1:0] wb_op_dest;
  logic                  wb_op_en;
  logic [DATA_W-1:0]     wb_result;

  modport master (
    output pipeline_reg_in, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wb_op_dest, wb_op_en, wb_result
  );

  modport slave (
    input  pipeline_reg_in, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wb_op_dest, wb_op_en, wb_result
  );

endinterface

// File: rtl/wb_stage_rf_reg_file_2r1w.sv
// 8x16 register file, one write port, two combinational read ports with
// write-through bypass. Optional hard-wired zero R0.
//   clk, rst      : clock, async active-low reset (clears all registers)
//   we/waddr/wdata: write port, committed on rising clk
//   raddr_*/rdata_*: read ports
module wb_stage_rf_reg_file_2r1w
  import wb_stage_rf_pkg::*;
#(
  parameter bit R0_ZERO = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_a,
  output logic [DATA_W-1:0]     rdata_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_live;

  // A write to a hard-wired R0 is dropped and never bypassed
  assign wr_live = we && !(R0_ZERO && (waddr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[REG_ADDR_W'(i)] <= '0;
      end
    end else if (wr_live) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port A with write-through bypass
  always_comb begin
    rdata_a = regs[raddr_a];
    if (R0_ZERO && (raddr_a == '0)) begin
      rdata_a = '0;
    end else if (wr_live && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end
  end

  // Read port B with write-through bypass
  always_comb begin
    rdata_b = regs[raddr_b];
    if (R0_ZERO && (raddr_b == '0)) begin
      rdata_b = '0;
    end else if (wr_live && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end
  end

endmodule

// File: rtl/wb_stage_rf.sv
// mips_16 write-back stage: selects the WB result from the MEM->WB register,
// commits it to the owned register file and counts committed writes.
//   clk, rst     : clock, async active-low reset
//   bus (slave)  : MEM->WB register, read ports, hazard/forwarding outputs
//   wb_count_clr : synchronous clear of wb_count (wins over an increment)
//   wb_count     : committed register writes, modulo 2^16
module wb_stage_rf
  import wb_stage_rf_pkg::*;
#(
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  wb_stage_rf_if.slave      bus,
  input  logic              wb_count_clr,
  output logic [DATA_W-1:0] wb_count
);

  mem_wb_t pr;
  logic    commit;

  assign pr = mem_wb_t'(bus.pipeline_reg_in);

  // Forwarding and hazard outputs are straight decodes of the WB register
  assign bus.wb_result  = wb_select(pr);
  assign bus.wb_op_dest = pr.wb_dest;
  assign bus.wb_op_en   = pr.wb_en;

  // Same drop rule as the register file, so R0 writes are not counted
  assign commit = pr.wb_en && !(R0_ZERO && (pr.wb_dest == '0));

  wb_stage_rf_reg_file_2r1w #(
    .R0_ZERO (R0_ZERO)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (pr.wb_en),
    .waddr   (pr.wb_dest),
    .wdata   (bus.wb_result),
    .raddr_a (bus.rd_addr_a),
    .raddr_b (bus.rd_addr_b),
    .rdata_a (bus.rd_data_a),
    .rdata_b (bus.rd_data_b)
  );

  // Write-back event counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_count <= '0;
    end else if (wb_count_clr) begin
      wb_count <= '0;
    end else if (commit) begin
      wb_count <= wb_count + DATA_W'(1);
    end
  end

endmodule
